plic_mt_core: RTL and testbench

// - Parametrised platform-level interrupt controller: NUM_SRC sources (IDs 1..NUM_SRC, ID 0 = "none").
// - NUM_TGT targets (harts/contexts). Per-source level/edge gateway; per-source priority.
// - Per-target enable mask, threshold and claim/complete. Sits between peripheral irq lines and core ext-irq pins.
// - Register access through a simple single-port register bus (bus bridge lives outside this block).

---
 rtl/plic_mt_pkg.sv | 33 +++
 rtl/plic_mt_arb.sv | 38 +++
 rtl/plic_mt_core.sv | 198 +++++++++++++++++++
 tb/tb_plic_mt_core.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/plic_mt_pkg.sv
// Shared constants and helpers for the multi-target PLIC.
// Holds the register map offsets, the supported maxima, a register-kind
// type used by the address decoder and a helper that computes the base
// address of a target's register block.
package plic_mt_pkg;

  localparam int MAX_SRC = 31;
  localparam int MAX_TGT = 8;

  localparam logic [11:0] PRIO_BASE  = 12'h000;
  localparam logic [11:0] IP_OFF     = 12'h080;
  localparam logic [11:0] EDGE_OFF   = 12'h084;
  localparam logic [11:0] TGT_BASE   = 12'h100;
  localparam logic [11:0] TGT_STRIDE = 12'h010;
  localparam logic [11:0] IE_OFF     = 12'h000;
  localparam logic [11:0] THOLD_OFF  = 12'h004;
  localparam logic [11:0] CC_OFF     = 12'h008;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_PRIO,
    REG_IP,
    REG_EDGE,
    REG_IE,
    REG_THOLD,
    REG_CC
  } reg_kind_e;

  function automatic logic [11:0] tgt_offset(input int t);
    return TGT_BASE + TGT_STRIDE * 12'(t);
  endfunction

endpackage

// File: rtl/plic_mt_arb.sv
// Combinational arbiter for one target.
// Picks the highest priority among the pending sources; ties resolve to
// the lowest ID. Priority 0 never wins, so no candidate yields ID 0.
// Ports:
//   pending  in  NUM_SRC             eligible sources (bit k-1 = ID k)
//   prio     in  NUM_SRC*PRIO_WIDTH  packed priorities (slice k-1 = ID k)
//   id       out ID_WIDTH            winning ID, 0 when none
//   best     out PRIO_WIDTH          winning priority, 0 when none
module plic_mt_arb
  import plic_mt_pkg::*;
#(
  parameter int NUM_SRC    = 31,
  parameter int PRIO_WIDTH = 3,
  parameter int ID_WIDTH   = $clog2(NUM_SRC + 1)
) (
  input  logic [NUM_SRC-1:0]            pending,
  input  logic [NUM_SRC*PRIO_WIDTH-1:0] prio,
  output logic [ID_WIDTH-1:0]           id,
  output logic [PRIO_WIDTH-1:0]         best
);

  logic [PRIO_WIDTH-1:0] cand;

  // Strict greater-than while scanning upward keeps the lowest ID on ties.
  always_comb begin
    id   = '0;
    best = '0;
    cand = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = prio[k*PRIO_WIDTH +: PRIO_WIDTH];
      if (pending[k] && (cand > best)) begin
        best = cand;
        id   = ID_WIDTH'(k + 1);
      end
    end
  end

endmodule

// File: rtl/plic_mt_core.sv
// Platform-level interrupt controller core.
// Per-source level/edge gateway, priority, per-target enable, threshold and
// claim/complete, accessed over a single-port register bus.
// Ports:
//   clk_i    in   1        clock
//   rst_i    in   1        synchronous reset, active-high
//   irq_i    in   NUM_SRC  raw source lines, bit k-1 = source ID k
//   req_i    in   1        register access strobe
//   we_i     in   1        1 = write, 0 = read
//   addr_i   in   12       byte address
//   wdata_i  in   32       write data
//   rdata_o  out  32       read data, valid the cycle after a read
//   irq_o    out  NUM_TGT  per-target interrupt request
module plic_mt_core
  import plic_mt_pkg::*;
#(
  parameter int NUM_SRC    = 31,
  parameter int NUM_TGT    = 2,
  parameter int PRIO_WIDTH = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [11:0]        addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic [NUM_TGT-1:0] irq_o
);

  localparam int ID_WIDTH = $clog2(NUM_SRC + 1);
  // Bits 1..NUM_SRC are real sources; bit 0 is reserved.
  localparam logic [31:0] SRC_MASK = 32'((64'd1 << (NUM_SRC + 1)) - 64'd2);

  logic [MAX_SRC:0]      src, irq_q, ip, edge_sel, inflight, edge_latch;
  logic [MAX_SRC:0]      ip_nxt, inflight_nxt, latch_nxt, inflight_eff;
  logic [MAX_SRC:0]      rise, lvl_set, edge_set, claim_mask, comp_mask;
  logic [PRIO_WIDTH-1:0] prio [NUM_SRC+1];
  logic [NUM_SRC*PRIO_WIDTH-1:0] prio_flat;
  logic [31:0]           ie [NUM_TGT];
  logic [PRIO_WIDTH-1:0] thold [NUM_TGT];
  logic [ID_WIDTH-1:0]   best_id [NUM_TGT], best_id_q [NUM_TGT];
  logic [PRIO_WIDTH-1:0] best_prio [NUM_TGT], best_prio_q [NUM_TGT];
  logic [NUM_SRC-1:0]    pend [NUM_TGT];

  reg_kind_e             kind;
  logic [4:0]            sel_src;
  logic [NUM_TGT-1:0]    tgt_hit;
  logic [31:0]           rd_val;
  logic [ID_WIDTH-1:0]   cc_id;
  logic                  rd_req, wr_req, comp_ok;

  assign rd_req = req_i && !we_i;
  assign wr_req = req_i && we_i;

  always_comb begin
    src = '0;
    src[NUM_SRC:1] = irq_i;
  end

  // Address decode
  always_comb begin
    kind    = REG_NONE;
    tgt_hit = '0;
    sel_src = addr_i[6:2];
    if (addr_i[11:7] == PRIO_BASE[11:7] && addr_i[1:0] == 2'b00 &&
        sel_src != 5'd0 && {1'b0, sel_src} <= 6'(NUM_SRC)) begin
      kind = REG_PRIO;
    end else if (addr_i == IP_OFF) begin
      kind = REG_IP;
    end else if (addr_i == EDGE_OFF) begin
      kind = REG_EDGE;
    end else begin
      for (int t = 0; t < NUM_TGT; t++) begin
        if (addr_i == tgt_offset(t) + IE_OFF) begin
          kind = REG_IE;
          tgt_hit[t] = 1'b1;
        end else if (addr_i == tgt_offset(t) + THOLD_OFF) begin
          kind = REG_THOLD;
          tgt_hit[t] = 1'b1;
        end else if (addr_i == tgt_offset(t) + CC_OFF) begin
          kind = REG_CC;
          tgt_hit[t] = 1'b1;
        end
      end
    end
  end

  // Read mux; cc_id is the ID a CLAIMCOMP read hands out this cycle.
  always_comb begin
    rd_val = '0;
    cc_id  = '0;
    case (kind)
      REG_PRIO: rd_val = 32'(prio[sel_src]);
      REG_IP:   rd_val = ip;
      REG_EDGE: rd_val = edge_sel;
      default: begin
        for (int t = 0; t < NUM_TGT; t++) begin
          if (tgt_hit[t]) begin
            if (kind == REG_IE)    rd_val = ie[t];
            if (kind == REG_THOLD) rd_val = 32'(thold[t]);
            if (kind == REG_CC) begin
              rd_val = 32'(best_id_q[t]);
              cc_id  = best_id_q[t];
            end
          end
        end
      end
    endcase
  end

  assign comp_ok = wr_req && kind == REG_CC && wdata_i != 32'd0 &&
                   wdata_i <= 32'(NUM_SRC) && inflight[wdata_i[4:0]];

  // Gateway and claim/complete bookkeeping. A complete frees the gateway
  // in the same edge, so a still-high level or a latched edge re-pends
  // the source immediately. A claim always overrides a concurrent set.
  always_comb begin
    claim_mask = '0;
    comp_mask  = '0;
    if (rd_req && kind == REG_CC && cc_id != '0) claim_mask[cc_id] = 1'b1;
    if (comp_ok) comp_mask[wdata_i[4:0]] = 1'b1;
    inflight_eff = inflight & ~comp_mask;
    rise         = src & ~irq_q;
    lvl_set      = src & ~edge_sel & ~inflight_eff & ~ip;
    edge_set     = edge_sel & (rise | edge_latch) & ~inflight_eff;
    ip_nxt       = (ip | lvl_set | edge_set) & ~claim_mask & SRC_MASK;
    inflight_nxt = (inflight_eff | claim_mask) & SRC_MASK;
    latch_nxt    = ((edge_latch & inflight_eff) | (edge_sel & rise & inflight_eff)) & SRC_MASK;
    if (wr_req && kind == REG_EDGE) latch_nxt = latch_nxt & ~((wdata_i & SRC_MASK) ^ edge_sel);
  end

  always_comb begin
    prio_flat = '0;
    for (int k = 1; k <= NUM_SRC; k++) prio_flat[(k-1)*PRIO_WIDTH +: PRIO_WIDTH] = prio[k];
  end

  for (genvar t = 0; t < NUM_TGT; t++) begin : g_arb
    assign pend[t] = ip[NUM_SRC:1] & ie[t][NUM_SRC:1];
    plic_mt_arb #(
      .NUM_SRC    (NUM_SRC),
      .PRIO_WIDTH (PRIO_WIDTH),
      .ID_WIDTH   (ID_WIDTH)
    ) u_arb (
      .pending (pend[t]),
      .prio    (prio_flat),
      .id      (best_id[t]),
      .best    (best_prio[t])
    );
  end

  always_comb begin
    for (int t = 0; t < NUM_TGT; t++)
      irq_o[t] = (best_id_q[t] != '0) && (best_prio_q[t] > thold[t]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q      <= '0;
      ip         <= '0;
      inflight   <= '0;
      edge_latch <= '0;
      edge_sel   <= '0;
      rdata_o    <= '0;
      for (int k = 0; k <= NUM_SRC; k++) prio[k] <= '0;
      for (int t = 0; t < NUM_TGT; t++) begin
        ie[t]          <= '0;
        thold[t]       <= '0;
        best_id_q[t]   <= '0;
        best_prio_q[t] <= '0;
      end
    end else begin
      irq_q      <= src;
      ip         <= ip_nxt;
      inflight   <= inflight_nxt;
      edge_latch <= latch_nxt;
      for (int t = 0; t < NUM_TGT; t++) begin
        best_id_q[t]   <= best_id[t];
        best_prio_q[t] <= best_prio[t];
      end
      if (rd_req) rdata_o <= rd_val;
      if (wr_req) begin
        case (kind)
          REG_PRIO: prio[sel_src] <= wdata_i[PRIO_WIDTH-1:0];
          REG_EDGE: edge_sel <= wdata_i & SRC_MASK;
          default: begin
            for (int t = 0; t < NUM_TGT; t++) begin
              if (tgt_hit[t] && kind == REG_IE)    ie[t]    <= wdata_i & SRC_MASK;
              if (tgt_hit[t] && kind == REG_THOLD) thold[t] <= wdata_i[PRIO_WIDTH-1:0];
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_plic_mt_core.sv
module tb_plic_mt_core;

  localparam logic [11:0] A_IP   = 12'h080;
  localparam logic [11:0] A_EDGE = 12'h084;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [30:0] irq_i = '0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [11:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic [1:0]  irq_o;

  int n_chk = 0;
  int n_pass = 0;

  // Reference state for the randomized section
  int          prio_m [32];
  logic [31:0] ie_m [2];
  int          thold_m [2];
  logic [31:0] ip_m;

  plic_mt_core #(.NUM_SRC(31), .NUM_TGT(2), .PRIO_WIDTH(3)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .irq_i   (irq_i),
    .req_i   (req_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o),
    .irq_o   (irq_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [11:0] a_prio(input int k);  return 12'(4 * k); endfunction
  function automatic logic [11:0] a_ie(input int t);    return 12'(256 + 16 * t); endfunction
  function automatic logic [11:0] a_thold(input int t); return 12'(256 + 16 * t + 4); endfunction
  function automatic logic [11:0] a_cc(input int t);    return 12'(256 + 16 * t + 8); endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
    @(negedge clk_i);
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; addr_i = a;
    @(negedge clk_i);
    req_i = 1'b0;
    d = rdata_o;
  endtask

  task automatic rd_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check_eq(tag, d, exp);
  endtask

  task automatic src_set(input int k, input logic v);
    irq_i[k-1] = v;
  endtask

  task automatic pulse(input int k);
    @(negedge clk_i); src_set(k, 1'b1);
    @(negedge clk_i); src_set(k, 1'b0);
    idle(2);
  endtask

  // Bounded wait: polls up to max_cyc cycles, then records the outcome.
  task automatic wait_irq(input string tag, input int t, input logic v, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (irq_o[t] === v) break;
      @(negedge clk_i);
    end
    check_eq(tag, 32'(irq_o[t]), 32'(v));
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; irq_i = '0;
    idle(2);
    rst_i = 1'b0;
  endtask

  // Highest enabled priority first, then the lowest ID holding it.
  task automatic model_best(input logic [31:0] pend, input logic [31:0] en,
                            output int id, output int pr);
    logic found;
    pr = 0; id = 0; found = 1'b0;
    for (int k = 1; k < 32; k++)
      if (pend[k] && en[k] && prio_m[k] > pr) pr = prio_m[k];
    if (pr > 0)
      for (int k = 1; k < 32; k++)
        if (!found && pend[k] && en[k] && prio_m[k] == pr) begin
          id = k; found = 1'b1;
        end
  endtask

  initial begin
    logic [31:0] d;
    int id0, pr0, id1, pr1, tc, to;

    // Reset with all lines high
    irq_i = '1;
    idle(3);
    check_eq("rst_irq_o", 32'(irq_o), 32'h0);
    check_eq("rst_rdata", rdata_o, 32'h0);
    irq_i = '0;
    rst_i = 1'b0;
    idle(1);
    rd_check("rst_ip", A_IP, 32'h0);
    rd_check("rst_ie0", a_ie(0), 32'h0);
    rd_check("rst_prio5", a_prio(5), 32'h0);
    rd_check("rst_cc0", a_cc(0), 32'h0);

    // Level source: latency, claim, complete with line still high
    do_reset();
    wr(a_prio(3), 32'd2);
    wr(a_ie(0), 32'h8);
    wr(a_thold(0), 32'd1);
    @(negedge clk_i); src_set(3, 1'b1);
    @(negedge clk_i); check_eq("lvl_irq_n1", 32'(irq_o[0]), 32'h0);
    @(negedge clk_i); check_eq("lvl_irq_n2", 32'(irq_o[0]), 32'h1);
    rd_check("lvl_claim", a_cc(0), 32'd3);
    check_eq("lvl_irq_claim_n1", 32'(irq_o[0]), 32'h1);
    @(negedge clk_i); check_eq("lvl_irq_claim_n2", 32'(irq_o[0]), 32'h0);
    rd_check("lvl_ip_after_claim", A_IP, 32'h0);
    wr(a_cc(0), 32'd3);
    rd_check("lvl_ip_after_comp", A_IP, 32'h8);
    wait_irq("lvl_irq_reassert", 0, 1'b1, 4);

    // Priority and ties on target 1
    do_reset();
    wr(a_prio(4), 32'd5);
    wr(a_prio(9), 32'd5);
    wr(a_prio(2), 32'd7);
    wr(a_ie(1), 32'hFFFF_FFFF);
    src_set(2, 1'b1); src_set(4, 1'b1); src_set(9, 1'b1);
    idle(3);
    rd_check("tie_ip", A_IP, 32'h214);
    rd_check("tie_claim1", a_cc(1), 32'd2);
    idle(1);
    rd_check("tie_claim2", a_cc(1), 32'd4);
    idle(1);
    rd_check("tie_claim3", a_cc(1), 32'd9);
    idle(1);
    rd_check("tie_claim_none", a_cc(1), 32'd0);

    // Threshold
    do_reset();
    wr(a_prio(6), 32'd3);
    wr(a_ie(0), 32'h40);
    wr(a_thold(0), 32'd3);
    src_set(6, 1'b1);
    idle(4);
    check_eq("thr_irq_masked", 32'(irq_o[0]), 32'h0);
    wr(a_thold(0), 32'd2);
    wait_irq("thr_irq_lowered", 0, 1'b1, 2);
    wr(a_thold(0), 32'd3);
    idle(2);
    check_eq("thr_irq_masked2", 32'(irq_o[0]), 32'h0);
    rd_check("thr_claim", a_cc(0), 32'd6);

    // Edge gateway with depth-1 latch
    do_reset();
    wr(A_EDGE, 32'h80);
    wr(a_prio(7), 32'd1);
    wr(a_ie(0), 32'h80);
    pulse(7);
    rd_check("edge_ip1", A_IP, 32'h80);
    rd_check("edge_claim1", a_cc(0), 32'd7);
    pulse(7);
    pulse(7);
    rd_check("edge_ip_inflight", A_IP, 32'h0);
    wr(a_cc(0), 32'd7);
    rd_check("edge_ip_relatch", A_IP, 32'h80);
    idle(2);
    rd_check("edge_claim2", a_cc(0), 32'd7);
    idle(1);
    wr(a_cc(0), 32'd7);
    idle(3);
    rd_check("edge_ip_final", A_IP, 32'h0);
    rd_check("edge_reg", A_EDGE, 32'h80);

    // Bogus completes and unmapped/reserved writes
    do_reset();
    wr(a_prio(5), 32'd1);
    wr(a_ie(1), 32'h20);
    src_set(5, 1'b1); src_set(31, 1'b1);
    idle(3);
    rd_check("bog_claim", a_cc(1), 32'd5);
    wr(a_cc(1), 32'd0);
    wr(a_cc(1), 32'd31);
    wr(a_cc(1), 32'd40);
    idle(2);
    rd_check("bog_ip", A_IP, 32'h8000_0000);
    wr(a_cc(1), 32'd5);
    rd_check("bog_ip_real_comp", A_IP, 32'h8000_0020);
    wr(12'h0FC, 32'hFFFF_FFFF);
    rd_check("unmapped_0fc", 12'h0FC, 32'h0);
    wr(a_ie(0), 32'h1);
    rd_check("ie_bit0", a_ie(0), 32'h0);
    rd_check("prio_after_junk", a_prio(31), 32'h0);

    // Randomized level-mode traffic against the reference model
    for (int it = 0; it < 30; it++) begin
      do_reset();
      prio_m[0] = 0;
      for (int k = 1; k < 32; k++) begin
        prio_m[k] = int'($urandom_range(0, 7));
        wr(a_prio(k), 32'(prio_m[k]));
      end
      for (int t = 0; t < 2; t++) begin
        ie_m[t] = $urandom & 32'hFFFF_FFFE;
        thold_m[t] = int'($urandom_range(0, 7));
        wr(a_ie(t), ie_m[t]);
        wr(a_thold(t), 32'(thold_m[t]));
      end
      irq_i = 31'($urandom);
      ip_m = {irq_i, 1'b0};
      idle(4);
      rd_check($sformatf("rnd%0d_ip", it), A_IP, ip_m);
      for (int t = 0; t < 2; t++) begin
        model_best(ip_m, ie_m[t], id0, pr0);
        check_eq($sformatf("rnd%0d_irq%0d", it, t), 32'(irq_o[t]), 32'(pr0 > thold_m[t]));
      end
      tc = int'($urandom_range(0, 1));
      to = 1 - tc;
      model_best(ip_m, ie_m[tc], id0, pr0);
      rd_check($sformatf("rnd%0d_claim_t%0d", it, tc), a_cc(tc), 32'(id0));
      if (id0 != 0) ip_m[id0] = 1'b0;
      idle(2);
      for (int t = 0; t < 2; t++) begin
        model_best(ip_m, ie_m[t], id1, pr1);
        check_eq($sformatf("rnd%0d_irq%0d_post", it, t), 32'(irq_o[t]), 32'(pr1 > thold_m[t]));
      end
      model_best(ip_m, ie_m[to], id1, pr1);
      rd_check($sformatf("rnd%0d_claim_t%0d", it, to), a_cc(to), 32'(id1));
      if (id1 != 0) ip_m[id1] = 1'b0;
      idle(1);
      rd_check($sformatf("rnd%0d_ip_claimed", it), A_IP, ip_m);
      if (id0 != 0) begin
        wr(a_cc(to), 32'(id0));
        ip_m[id0] = 1'b1;
      end
      idle(2);
      rd_check($sformatf("rnd%0d_ip_comp", it), A_IP, ip_m);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
